// File: rtl/mul_seq_pkg.sv
// Shared definitions for the s1269 multiply front-end: sequencer states and
// the INS opcode set used by this block and the datapath bench.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_DR,
        LD_MQ,
        LD_ACC,
        EXEC,
        RD_ACC,
        RD_MQ,
        RESP
    } seq_state_t;

    localparam logic [2:0] INS_NOP = 3'd0;
    localparam logic [2:0] INS_MUL = 3'd1;
    localparam logic [2:0] INS_MAC = 3'd2;
    localparam logic [2:0] INS_SHL = 3'd3;
    localparam logic [2:0] INS_SHR = 3'd4;
    localparam logic [2:0] INS_ADD = 3'd5;
    localparam logic [2:0] INS_SUB = 3'd6;
    localparam logic [2:0] INS_CLR = 3'd7;

endpackage

// File: rtl/mul_bus_sequencer.sv
// Command front-end for the s1269 shift/add multiplier: loads DR/MQ/Acc,
// runs INS until RDY (or timeout), reads Acc/MQ back and returns the result.
module mul_bus_sequencer
    import mul_seq_pkg::*;
#(
    parameter int TIMEOUT  = 64,
    parameter int EXEC_MIN = 2,
    parameter int CW       = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [7:0] cmd_acc,
    input  logic       cmd_ld_acc,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       rsp_err,
    output logic       busy,
    output logic [2:0] INS,
    output logic       LDAcc,
    output logic       LDMQ,
    output logic       LDDR,
    output logic       STAcc,
    output logic       STMQ,
    output logic       STDR,
    output logic       TESTMODE,
    output logic [7:0] inBUS,
    input  logic [7:0] outBUS,
    input  logic       RDY
);

    localparam logic [CW-1:0] EXEC_MIN_C = CW'(EXEC_MIN);
    localparam logic [CW-1:0] EXEC_LAST  = CW'(TIMEOUT - 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic [2:0]    op_q;
    logic [7:0]    a_q;
    logic [7:0]    acc_q;
    logic          ld_acc_q;
    logic [CW-1:0] cnt;
    logic          err_set;
    logic [7:0]    inbus_next;
    logic [2:0]    ins_next;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign TESTMODE  = 1'b0;

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        case (state)
            IDLE:    if (cmd_valid) state_next = LD_DR;
            LD_DR:   state_next = LD_MQ;
            LD_MQ:   state_next = ld_acc_q ? LD_ACC : EXEC;
            LD_ACC:  state_next = EXEC;
            EXEC: begin
                // RDY is only trusted once the stale idle level has been masked
                if (RDY && (cnt >= EXEC_MIN_C)) begin
                    state_next = RD_ACC;
                end else if (cnt == EXEC_LAST) begin
                    state_next = RD_ACC;
                    err_set    = 1'b1;
                end
            end
            RD_ACC:  state_next = RD_MQ;
            RD_MQ:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath outputs are registered from the next state so they line up
    // exactly with the cycle spent in the corresponding state.
    always_comb begin
        inbus_next = '0;
        ins_next   = INS_NOP;
        case (state_next)
            LD_DR:   inbus_next = cmd_b;
            LD_MQ:   inbus_next = a_q;
            LD_ACC:  inbus_next = acc_q;
            EXEC:    ins_next   = op_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            ld_acc_q <= 1'b0;
            cnt      <= '0;
            rsp_err  <= 1'b0;
            rsp_hi   <= '0;
            rsp_lo   <= '0;
            rsp_valid <= 1'b0;
            INS      <= INS_NOP;
            inBUS    <= '0;
            LDDR     <= 1'b0;
            LDMQ     <= 1'b0;
            LDAcc    <= 1'b0;
            STAcc    <= 1'b0;
            STMQ     <= 1'b0;
            STDR     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                a_q      <= cmd_a;
                acc_q    <= cmd_acc;
                ld_acc_q <= cmd_ld_acc;
            end
            cnt <= (state == EXEC && state_next == EXEC) ? cnt + 1'b1 : '0;
            if (err_set) begin
                rsp_err <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_err <= 1'b0;
            end
            if (state == RD_ACC) rsp_hi <= outBUS;
            if (state == RD_MQ)  rsp_lo <= outBUS;
            rsp_valid <= (state_next == RESP);
            INS       <= ins_next;
            inBUS     <= inbus_next;
            LDDR      <= (state_next == LD_DR);
            LDMQ      <= (state_next == LD_MQ);
            LDAcc     <= (state_next == LD_ACC);
            STAcc     <= (state_next == RD_ACC);
            STMQ      <= (state_next == RD_MQ);
            STDR      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_bus_sequencer.sv
// Directed + randomized bench for mul_bus_sequencer with a stub datapath
// and a task-level reference of the expected transaction behaviour.
module tb_mul_bus_sequencer;
    import mul_seq_pkg::*;

    localparam int TIMEOUT  = 64;
    localparam int EXEC_MIN = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready, cmd_ld_acc;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a, cmd_b, cmd_acc;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_hi, rsp_lo;
    logic [2:0] INS;
    logic       LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, TESTMODE;
    logic [7:0] inBUS, outBUS;
    logic       RDY;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_acc = '0;

    always #5 clock = ~clock;

    mul_bus_sequencer #(.TIMEOUT(TIMEOUT), .EXEC_MIN(EXEC_MIN), .CW(7)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .cmd_ld_acc(cmd_ld_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi),
        .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy), .INS(INS),
        .LDAcc(LDAcc), .LDMQ(LDMQ), .LDDR(LDDR), .STAcc(STAcc), .STMQ(STMQ),
        .STDR(STDR), .TESTMODE(TESTMODE), .inBUS(inBUS), .outBUS(outBUS), .RDY(RDY)
    );

    // Stub datapath: latches loads, presents {Acc,0} + DR*MQ on readback.
    logic [7:0]  dp_dr, dp_mq, dp_acc;
    logic [15:0] dp_res;
    always @(posedge clock) begin
        if (LDDR)  dp_dr  <= inBUS;
        if (LDMQ)  dp_mq  <= inBUS;
        if (LDAcc) dp_acc <= inBUS;
    end
    assign dp_res = {dp_acc, 8'h00} + 16'(dp_dr) * 16'(dp_mq);
    assign outBUS = STAcc ? dp_res[15:8] : (STMQ ? dp_res[7:0] : 8'hA5);

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    // k = EXEC cycle index at which RDY first rises (0 means RDY held high).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] acc,
                          input logic ld, input logic [2:0] op, input int k,
                          input int bp, input bit keep_valid);
        int ld_kind[$];
        int ld_val[$];
        int exec_n = 0;
        int lat = -1;
        int nstb;
        int exp_n, exp_lat;
        bit got = 0, multi = 0, bus_bad = 0, ins_bad = 0, rsvd_bad = 0;
        bit stall_bad = 0, bp_bad = 0;
        bit rdy_always;
        bit exp_err;
        logic [15:0] exp_res;
        logic [7:0]  hold_hi, hold_lo;

        rdy_always = (k == 0);
        cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_ld_acc = ld; cmd_op = op;
        cmd_valid = 1'b1;
        RDY = rdy_always;
        check("accept_ready", int'(cmd_ready), 1);
        if (ld) model_acc = acc;

        for (int j = 1; j <= 200 && !got; j++) begin
            @(negedge clock);
            if (!keep_valid) cmd_valid = 1'b0;
            if (cmd_ready) stall_bad = 1;
            nstb = int'(LDDR) + int'(LDMQ) + int'(LDAcc) + int'(STAcc) + int'(STMQ) + int'(STDR);
            if (nstb > 1) multi = 1;
            if (LDDR)  begin ld_kind.push_back(0); ld_val.push_back(int'(inBUS)); end
            if (LDMQ)  begin ld_kind.push_back(1); ld_val.push_back(int'(inBUS)); end
            if (LDAcc) begin ld_kind.push_back(2); ld_val.push_back(int'(inBUS)); end
            if (!(LDDR || LDMQ || LDAcc) && inBUS !== 8'h00) bus_bad = 1;
            if (STDR !== 1'b0 || TESTMODE !== 1'b0) rsvd_bad = 1;
            if (rsp_valid) begin
                got = 1;
                lat = j - 1;
                rsp_ready = 1'b0;
            end else if (busy && nstb == 0) begin
                if (INS !== op) ins_bad = 1;
                RDY = rdy_always || (exec_n >= k);
                exec_n++;
                rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                if (INS !== 3'd0) ins_bad = 1;
                RDY = rdy_always;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end

        exp_err = (k >= TIMEOUT);
        exp_n   = exp_err ? TIMEOUT : ((k > EXEC_MIN ? k : EXEC_MIN) + 1);
        exp_lat = (ld ? 5 : 4) + exp_n;
        exp_res = {model_acc, 8'h00} + 16'(a) * 16'(b);

        check("rsp_arrived", int'(got), 1);
        check("load_count", ld_kind.size(), ld ? 3 : 2);
        if (ld_kind.size() >= 2) begin
            check("load0_is_dr", ld_kind[0], 0);
            check("load0_bus", ld_val[0], int'(b));
            check("load1_is_mq", ld_kind[1], 1);
            check("load1_bus", ld_val[1], int'(a));
        end
        if (ld && ld_kind.size() == 3) begin
            check("load2_is_acc", ld_kind[2], 2);
            check("load2_bus", ld_val[2], int'(acc));
        end
        check("exec_cycles", exec_n, exp_n);
        check("latency", lat, exp_lat);
        check("rsp_hi", int'(rsp_hi), int'(exp_res[15:8]));
        check("rsp_lo", int'(rsp_lo), int'(exp_res[7:0]));
        check("rsp_err", int'(rsp_err), int'(exp_err));
        check("onehot_strobes", int'(multi), 0);
        check("inbus_idle_zero", int'(bus_bad), 0);
        check("ins_hold", int'(ins_bad), 0);
        check("reserved_zero", int'(rsvd_bad), 0);
        check("no_accept_busy", int'(stall_bad), 0);

        hold_hi = rsp_hi;
        hold_lo = rsp_lo;
        for (int c = 0; c < bp; c++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_hi !== hold_hi || rsp_lo !== hold_lo ||
                rsp_err !== exp_err || cmd_ready !== 1'b0) bp_bad = 1;
        end
        check("backpressure_stable", int'(bp_bad), 0);

        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("post_hs_valid", int'(rsp_valid), 0);
        check("post_hs_err", int'(rsp_err), 0);
        check("post_hs_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_acc = '0;
        cmd_ld_acc = 1'b0; rsp_ready = 1'b0; RDY = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'({rsp_hi, rsp_lo}), 0);
        check("reset_strobes", int'({LDDR, LDMQ, LDAcc, STAcc, STMQ, STDR}), 0);
        check("reset_bus", int'({INS, inBUS}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // basic, accumulate, stale RDY, timeout and the timeout boundary
        run_op(8'h05, 8'h03, 8'h00, 1'b1, INS_MUL, 10, 0, 1'b0);
        run_op(8'h07, 8'h09, 8'h00, 1'b0, INS_MAC, 10, 0, 1'b0);
        run_op(8'h11, 8'h0E, 8'h22, 1'b1, INS_ADD, 0, 0, 1'b0);
        run_op(8'h3C, 8'h44, 8'h01, 1'b1, INS_MUL, 200, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'hFF, 1'b1, INS_SHL, TIMEOUT - 1, 1, 1'b0);
        run_op(8'h80, 8'h02, 8'h10, 1'b0, INS_SHR, TIMEOUT, 1, 1'b0);

        // backpressure with a second command already waiting
        run_op(8'h12, 8'h34, 8'h56, 1'b1, INS_MAC, 5, 20, 1'b1);
        run_op(8'h12, 8'h34, 8'h56, 1'b1, INS_MAC, 5, 0, 1'b0);

        // asynchronous reset in the middle of EXEC
        cmd_a = 8'h21; cmd_b = 8'h43; cmd_acc = 8'h65; cmd_ld_acc = 1'b1;
        cmd_op = INS_SUB; cmd_valid = 1'b1; RDY = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("pre_reset_exec_ins", int'(INS), int'(INS_SUB));
        reset_n = 1'b0;
        #1;
        check("async_cmd_ready", int'(cmd_ready), 1);
        check("async_busy", int'(busy), 0);
        check("async_strobes", int'({LDDR, LDMQ, LDAcc, STAcc, STMQ, STDR}), 0);
        check("async_bus", int'({INS, inBUS}), 0);
        check("async_rsp", int'({rsp_valid, rsp_err}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(8'h0A, 8'h0B, 8'h02, 1'b1, INS_MUL, 4, 2, 1'b0);

        for (int n = 0; n < 10; n++) begin
            run_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   3'($urandom), int'($urandom_range(0, 70)), int'($urandom_range(0, 4)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
